issue_dispatcher: RTL

Parametrised in-order issue stage between instruction fetch and the out-of-order back end. It buffers fetched instructions in an internal FIFO and presents the head to the decoder. It resolves both source operands from register file, ROB and N result buses, then issues one instruction per cycle into ROB + RS or ROB + LSB, with a register-rename update. Compared with the single-entry dispatcher it adds a fetch queue, configurable tag/data width, a configurable number of forwarding buses, x0 rename suppression and flush-safe draining.

---
 rtl/issue_dispatcher.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/issue_dispatcher.sv
// In-order issue stage: fetch queue, operand resolution (RF/ROB/result buses), one issue per cycle.
// Optional macro ISSUE_CDB_FWD_EN enables result-bus forwarding; without it cdb_* inputs are ignored.
module issue_dispatcher #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 5,
  parameter int CDB_PORTS = 2,
  parameter int IQ_DEPTH  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rdy_i,
  input  logic                      flush_i,
  input  logic                      if_valid_i,
  input  logic [31:0]               if_inst_i,
  input  logic [XLEN-1:0]           if_pc_i,
  input  logic                      if_jump_i,
  output logic                      if_ready_o,
  output logic [31:0]               dec_inst_o,
  input  logic [4:0]                dec_rd_i,
  input  logic [4:0]                dec_rs1_i,
  input  logic [4:0]                dec_rs2_i,
  input  logic [6:0]                dec_op_i,
  input  logic [XLEN-1:0]           dec_imm_i,
  input  logic                      dec_is_jump_i,
  input  logic                      dec_is_ls_i,
  output logic [4:0]                rf_rs1_o,
  output logic [4:0]                rf_rs2_o,
  input  logic [TAG_W-1:0]          rf_Qi_i,
  input  logic [TAG_W-1:0]          rf_Qj_i,
  input  logic [XLEN-1:0]           rf_Vi_i,
  input  logic [XLEN-1:0]           rf_Vj_i,
  output logic [TAG_W-1:0]          rob_chk_i_o,
  output logic [TAG_W-1:0]          rob_chk_j_o,
  input  logic                      rob_rdy_i_i,
  input  logic                      rob_rdy_j_i,
  input  logic [XLEN-1:0]           rob_val_i_i,
  input  logic [XLEN-1:0]           rob_val_j_i,
  input  logic                      rob_full_i,
  input  logic                      rs_full_i,
  input  logic                      lsb_full_i,
  input  logic [TAG_W-1:0]          rob_free_tag_i,
  input  logic [CDB_PORTS-1:0]      cdb_valid_i,
  input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag_i,
  input  logic [CDB_PORTS*XLEN-1:0] cdb_data_i,
  output logic                      rob_issue_o,
  output logic                      rs_issue_o,
  output logic                      lsb_issue_o,
  output logic [XLEN-1:0]           iss_pc_o,
  output logic [XLEN-1:0]           iss_imm_o,
  output logic [6:0]                iss_op_o,
  output logic [4:0]                iss_rd_o,
  output logic [TAG_W-1:0]          iss_tag_o,
  output logic [TAG_W-1:0]          iss_Qi_o,
  output logic [TAG_W-1:0]          iss_Qj_o,
  output logic [XLEN-1:0]           iss_Vi_o,
  output logic [XLEN-1:0]           iss_Vj_o,
  output logic                      iss_pred_o,
  output logic                      iss_is_jump_o,
  output logic                      rf_ren_valid_o,
  output logic [4:0]                rf_ren_rd_o,
  output logic [TAG_W-1:0]          rf_ren_tag_o
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]       inst_q [IQ_DEPTH];
  logic [XLEN-1:0]   pc_q   [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] jump_q;
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q;

  logic              rob_issue_q, rs_issue_q, lsb_issue_q;
  logic [XLEN-1:0]   iss_pc_q, iss_imm_q, iss_vi_q, iss_vj_q;
  logic [6:0]        iss_op_q;
  logic [4:0]        iss_rd_q, ren_rd_q;
  logic [TAG_W-1:0]  iss_tag_q, iss_qi_q, iss_qj_q, ren_tag_q;
  logic              iss_pred_q, iss_is_jump_q, ren_valid_q;

  logic              push, fire;
  logic [TAG_W-1:0]  qi_d, qj_d;
  logic [XLEN-1:0]   vi_d, vj_d;

  assign if_ready_o  = (count_q < CW'(IQ_DEPTH));
  assign dec_inst_o  = inst_q[head_q];
  assign rf_rs1_o    = dec_rs1_i;
  assign rf_rs2_o    = dec_rs2_i;
  assign rob_chk_i_o = rf_Qi_i;
  assign rob_chk_j_o = rf_Qj_j_sel();

  function automatic logic [TAG_W-1:0] rf_Qj_j_sel();
    return rf_Qj_i;
  endfunction

  assign push = if_valid_i && if_ready_o && rdy_i && !flush_i;
  assign fire = (count_q != '0) && !rob_full_i && !rs_full_i && !lsb_full_i && rdy_i && !flush_i;

  // Returns {Q, V}. A zero RF tag means the RF value is already valid, so ROB/bus lookups are skipped.
  function automatic logic [TAG_W+XLEN-1:0] resolve(
    input logic [TAG_W-1:0]           q,
    input logic [XLEN-1:0]            v,
    input logic                       rob_rdy,
    input logic [XLEN-1:0]            rob_val,
    input logic [CDB_PORTS-1:0]       cv,
    input logic [CDB_PORTS*TAG_W-1:0] ct,
    input logic [CDB_PORTS*XLEN-1:0]  cd
  );
    logic [TAG_W-1:0] rq;
    logic [XLEN-1:0]  rv;
    logic             hit;
    rq  = q;
    rv  = v;
    hit = 1'b0;
    if (q != '0 && rob_rdy) begin
      rq = '0;
      rv = rob_val;
    end
`ifdef ISSUE_CDB_FWD_EN
    for (int k = 0; k < CDB_PORTS; k++) begin
      if (!hit && q != '0 && cv[k] && ct[k*TAG_W +: TAG_W] == q) begin
        hit = 1'b1;
        rq  = '0;
        rv  = cd[k*XLEN +: XLEN];
      end
    end
`else
    hit = ^{hit, cv, ct, cd};
`endif
    return {rq, rv};
  endfunction

  always_comb begin
    {qi_d, vi_d} = resolve(rf_Qi_i, rf_Vi_i, rob_rdy_i_i, rob_val_i_i,
                           cdb_valid_i, cdb_tag_i, cdb_data_i);
    {qj_d, vj_d} = resolve(rf_Qj_i, rf_Vj_i, rob_rdy_j_i, rob_val_j_i,
                           cdb_valid_i, cdb_tag_i, cdb_data_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      jump_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      rob_issue_q   <= 1'b0;
      rs_issue_q    <= 1'b0;
      lsb_issue_q   <= 1'b0;
      iss_pc_q      <= '0;
      iss_imm_q     <= '0;
      iss_op_q      <= '0;
      iss_rd_q      <= '0;
      iss_tag_q     <= '0;
      iss_qi_q      <= '0;
      iss_qj_q      <= '0;
      iss_vi_q      <= '0;
      iss_vj_q      <= '0;
      iss_pred_q    <= 1'b0;
      iss_is_jump_q <= 1'b0;
      ren_valid_q   <= 1'b0;
      ren_rd_q      <= '0;
      ren_tag_q     <= '0;
    end else if (rdy_i) begin
      if (push) begin
        inst_q[tail_q] <= if_inst_i;
        pc_q[tail_q]   <= if_pc_i;
        jump_q[tail_q] <= if_jump_i;
        tail_q         <= tail_q + PW'(1);
      end
      if (fire) head_q <= head_q + PW'(1);
      case ({push, fire})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      rob_issue_q <= fire;
      rs_issue_q  <= fire && !dec_is_ls_i;
      lsb_issue_q <= fire && dec_is_ls_i;
      ren_valid_q <= fire && (dec_rd_i != 5'd0);
      if (fire) begin
        iss_pc_q      <= pc_q[head_q];
        iss_imm_q     <= dec_imm_i;
        iss_op_q      <= dec_op_i;
        iss_rd_q      <= dec_rd_i;
        iss_tag_q     <= rob_free_tag_i;
        iss_qi_q      <= qi_d;
        iss_qj_q      <= qj_d;
        iss_vi_q      <= vi_d;
        iss_vj_q      <= vj_d;
        iss_pred_q    <= jump_q[head_q];
        iss_is_jump_q <= dec_is_jump_i;
        ren_rd_q      <= dec_rd_i;
        ren_tag_q     <= rob_free_tag_i;
      end
    end
  end

  assign rob_issue_o    = rob_issue_q;
  assign rs_issue_o     = rs_issue_q;
  assign lsb_issue_o    = lsb_issue_q;
  assign iss_pc_o       = iss_pc_q;
  assign iss_imm_o      = iss_imm_q;
  assign iss_op_o       = iss_op_q;
  assign iss_rd_o       = iss_rd_q;
  assign iss_tag_o      = iss_tag_q;
  assign iss_Qi_o       = iss_qi_q;
  assign iss_Qj_o       = iss_qj_q;
  assign iss_Vi_o       = iss_vi_q;
  assign iss_Vj_o       = iss_vj_q;
  assign iss_pred_o     = iss_pred_q;
  assign iss_is_jump_o  = iss_is_jump_q;
  assign rf_ren_valid_o = ren_valid_q;
  assign rf_ren_rd_o    = ren_rd_q;
  assign rf_ren_tag_o   = ren_tag_q;

endmodule
